// File: rtl/int_nest_sequencer.sv
// Interrupt nesting sequencer: dispatches prioritised interrupts to the CPU,
// tracks nested handlers on a LIFO stack and acknowledges start/end to the controller.
module int_nest_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_gie,
    input  logic        int_flag,
    input  logic [4:0]  int_id,
    input  logic [2:0]  int_priority,
    input  logic [31:0] ivt_base,
    input  logic        irq_ack,
    input  logic        cpu_reti,
    output logic        gie,
    output logic        irq_req,
    output logic [31:0] irq_vector,
    output logic        ack_start,
    output logic [4:0]  ack_start_id,
    output logic        ack_end,
    output logic [4:0]  ack_end_id,
    output logic        active_valid,
    output logic [4:0]  active_id,
    output logic [2:0]  active_priority,
    output logic [3:0]  depth,
    output logic        err_reti
);

    localparam logic [3:0] DEPTH_W = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_START = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  lat_id_q, lat_id_d;
    logic [2:0]  lat_pri_q, lat_pri_d;
    logic [4:0]  stk_id_q  [DEPTH];
    logic [4:0]  stk_id_d  [DEPTH];
    logic [2:0]  stk_pri_q [DEPTH];
    logic [2:0]  stk_pri_d [DEPTH];
    logic [3:0]  depth_q, depth_d;
    logic        reti_pend_q, reti_pend_d;
    logic        err_reti_q, err_reti_d;
    logic        irq_req_q, irq_req_d;
    logic [31:0] irq_vector_q, irq_vector_d;
    logic        ack_start_q, ack_start_d;
    logic [4:0]  ack_start_id_q, ack_start_id_d;
    logic        ack_end_q, ack_end_d;
    logic [4:0]  ack_end_id_q, ack_end_id_d;
    logic        active_valid_q, active_valid_d;
    logic [4:0]  active_id_q, active_id_d;
    logic [2:0]  active_pri_q, active_pri_d;
    logic        eligible_s;

    assign gie = sw_gie;

    // New request may preempt only a strictly lower-priority (numerically larger) handler
    always_comb begin
        eligible_s = int_flag && sw_gie && (depth_q < DEPTH_W) &&
                     ((depth_q == 4'd0) || (int_priority < active_pri_q));
    end

    // Next-state, stack update and registered-output precomputation
    always_comb begin
        state_d        = state_q;
        lat_id_d       = lat_id_q;
        lat_pri_d      = lat_pri_q;
        stk_id_d       = stk_id_q;
        stk_pri_d      = stk_pri_q;
        depth_d        = depth_q;
        reti_pend_d    = reti_pend_q;
        err_reti_d     = err_reti_q;
        irq_vector_d   = irq_vector_q;
        ack_start_id_d = ack_start_id_q;
        ack_end_id_d   = ack_end_id_q;
        active_id_d    = active_id_q;
        active_pri_d   = active_pri_q;

        // In START the push lands this edge, so the stack is never empty for a reti
        if (cpu_reti && !reti_pend_q) begin
            if ((state_q == S_START) || (depth_q != 4'd0)) begin
                reti_pend_d = 1'b1;
            end else begin
                err_reti_d = 1'b1;
            end
        end else begin
            reti_pend_d = reti_pend_q;
        end

        case (state_q)
            S_IDLE: begin
                if (reti_pend_d && (depth_q != 4'd0)) begin
                    state_d      = S_END;
                    ack_end_id_d = active_id_q;
                end else if (eligible_s) begin
                    state_d      = S_REQ;
                    lat_id_d     = int_id;
                    lat_pri_d    = int_priority;
                    irq_vector_d = ivt_base + {25'd0, int_id, 2'b00};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    state_d        = S_START;
                    ack_start_id_d = lat_id_q;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_START: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (4'(i) == depth_q) begin
                        stk_id_d[i]  = lat_id_q;
                        stk_pri_d[i] = lat_pri_q;
                    end else begin
                        stk_id_d[i]  = stk_id_q[i];
                        stk_pri_d[i] = stk_pri_q[i];
                    end
                end
                depth_d      = depth_q + 4'd1;
                active_id_d  = lat_id_q;
                active_pri_d = lat_pri_q;
                state_d      = S_IDLE;
            end
            S_END: begin
                active_id_d  = 5'd0;
                active_pri_d = 3'd0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (4'(i) + 4'd1 == depth_q) begin
                        stk_id_d[i]  = 5'd0;
                        stk_pri_d[i] = 3'd0;
                    end else if (4'(i) + 4'd2 == depth_q) begin
                        active_id_d  = stk_id_q[i];
                        active_pri_d = stk_pri_q[i];
                    end else begin
                        stk_id_d[i]  = stk_id_q[i];
                    end
                end
                depth_d     = depth_q - 4'd1;
                reti_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        irq_req_d      = (state_d == S_REQ);
        ack_start_d    = (state_d == S_START);
        ack_end_d      = (state_d == S_END);
        active_valid_d = (depth_d != 4'd0);
    end

    // State, stack and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            lat_id_q       <= 5'd0;
            lat_pri_q      <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_id_q[i]  <= 5'd0;
                stk_pri_q[i] <= 3'd0;
            end
            depth_q        <= 4'd0;
            reti_pend_q    <= 1'b0;
            err_reti_q     <= 1'b0;
            irq_req_q      <= 1'b0;
            irq_vector_q   <= 32'd0;
            ack_start_q    <= 1'b0;
            ack_start_id_q <= 5'd0;
            ack_end_q      <= 1'b0;
            ack_end_id_q   <= 5'd0;
            active_valid_q <= 1'b0;
            active_id_q    <= 5'd0;
            active_pri_q   <= 3'd0;
        end else begin
            state_q        <= state_d;
            lat_id_q       <= lat_id_d;
            lat_pri_q      <= lat_pri_d;
            stk_id_q       <= stk_id_d;
            stk_pri_q      <= stk_pri_d;
            depth_q        <= depth_d;
            reti_pend_q    <= reti_pend_d;
            err_reti_q     <= err_reti_d;
            irq_req_q      <= irq_req_d;
            irq_vector_q   <= irq_vector_d;
            ack_start_q    <= ack_start_d;
            ack_start_id_q <= ack_start_id_d;
            ack_end_q      <= ack_end_d;
            ack_end_id_q   <= ack_end_id_d;
            active_valid_q <= active_valid_d;
            active_id_q    <= active_id_d;
            active_pri_q   <= active_pri_d;
        end
    end

    assign irq_req         = irq_req_q;
    assign irq_vector      = irq_vector_q;
    assign ack_start       = ack_start_q;
    assign ack_start_id    = ack_start_id_q;
    assign ack_end         = ack_end_q;
    assign ack_end_id      = ack_end_id_q;
    assign active_valid    = active_valid_q;
    assign active_id       = active_id_q;
    assign active_priority = active_pri_q;
    assign depth           = depth_q;
    assign err_reti        = err_reti_q;

endmodule

// File: tb/tb_int_nest_sequencer.sv
// Self-checking bench for int_nest_sequencer: directed scenarios plus random
// dispatch/return traffic checked against a queue-based nesting model.
module tb_int_nest_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_gie, int_flag, irq_ack, cpu_reti;
    logic [4:0]  int_id;
    logic [2:0]  int_priority;
    logic [31:0] ivt_base;
    logic        gie, irq_req, ack_start, ack_end, active_valid, err_reti;
    logic [31:0] irq_vector;
    logic [4:0]  ack_start_id, ack_end_id, active_id;
    logic [2:0]  active_priority;
    logic [3:0]  depth;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the handler nesting stack as queues, plus the sticky error flag
    logic [4:0] m_id  [$];
    logic [2:0] m_pri [$];
    logic       m_err = 1'b0;

    int_nest_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .sw_gie(sw_gie), .int_flag(int_flag),
        .int_id(int_id), .int_priority(int_priority), .ivt_base(ivt_base),
        .irq_ack(irq_ack), .cpu_reti(cpu_reti), .gie(gie), .irq_req(irq_req),
        .irq_vector(irq_vector), .ack_start(ack_start), .ack_start_id(ack_start_id),
        .ack_end(ack_end), .ack_end_id(ack_end_id), .active_valid(active_valid),
        .active_id(active_id), .active_priority(active_priority), .depth(depth),
        .err_reti(err_reti)
    );

    always #5 clk = ~clk;

    task automatic do_dispatch(input logic [4:0] id, input logic [2:0] pri, input logic g,
                               input logic [31:0] base, input int hold);
        logic        exp_el;
        logic [31:0] exp_vec;
        int          sz;
        sz      = m_id.size();
        exp_el  = g && (sz < 4) && ((sz == 0) || (pri < m_pri[sz-1]));
        exp_vec = base + 32'(id) * 32'd4;
        @(negedge clk);
        int_flag = 1'b1; int_id = id; int_priority = pri; sw_gie = g; ivt_base = base;
        #1;
        n_checks++;
        if (gie !== g) begin n_fail++; $display("FAIL gie: got %0b want %0b", gie, g); end
        @(negedge clk);
        n_checks++;
        if (irq_req !== exp_el) begin
            n_fail++; $display("FAIL irq_req id=%0d pri=%0d: got %0b want %0b", id, pri, irq_req, exp_el);
        end
        if (exp_el && irq_req === 1'b1) begin
            n_checks++;
            if (irq_vector !== exp_vec) begin
                n_fail++; $display("FAIL irq_vector: got %h want %h", irq_vector, exp_vec);
            end
            for (int k = 0; k < hold; k++) begin
                int_flag = 1'($urandom); int_id = 5'($urandom); int_priority = 3'($urandom);
                sw_gie = 1'($urandom);
                @(negedge clk);
                n_checks++;
                if (irq_req !== 1'b1 || irq_vector !== exp_vec || ack_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_hold: req=%0b vec=%h ack_start=%0b want 1/%h/0",
                             irq_req, irq_vector, ack_start, exp_vec);
                end
            end
            irq_ack = 1'b1; int_flag = 1'b0; sw_gie = 1'b1;
            @(negedge clk);
            irq_ack = 1'b0;
            n_checks++;
            if (ack_start !== 1'b1 || ack_start_id !== id || irq_req !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_start: ack=%0b id=%0d req=%0b want 1/%0d/0",
                         ack_start, ack_start_id, irq_req, id);
            end
            m_id.push_back(id); m_pri.push_back(pri);
            @(negedge clk);
            n_checks++;
            if (ack_start !== 1'b0 || depth !== 4'(m_id.size()) || active_valid !== 1'b1 ||
                active_id !== id || active_priority !== pri) begin
                n_fail++;
                $display("FAIL after_push: ack=%0b depth=%0d valid=%0b id=%0d pri=%0d want 0/%0d/1/%0d/%0d",
                         ack_start, depth, active_valid, active_id, active_priority,
                         m_id.size(), id, pri);
            end
        end else begin
            int_flag = 1'b0; sw_gie = 1'b1;
            @(negedge clk);
            n_checks++;
            if (irq_req !== 1'b0 || ack_start !== 1'b0 || depth !== 4'(m_id.size())) begin
                n_fail++;
                $display("FAIL blocked: req=%0b ack=%0b depth=%0d want 0/0/%0d",
                         irq_req, ack_start, depth, m_id.size());
            end
        end
    endtask

    task automatic do_reti();
        logic [4:0] top;
        @(negedge clk); cpu_reti = 1'b1;
        @(negedge clk); cpu_reti = 1'b0;
        if (m_id.size() > 0) begin
            top = m_id[m_id.size()-1];
            n_checks++;
            if (ack_end !== 1'b1 || ack_end_id !== top) begin
                n_fail++; $display("FAIL ack_end: ack=%0b id=%0d want 1/%0d", ack_end, ack_end_id, top);
            end
            void'(m_id.pop_back()); void'(m_pri.pop_back());
            @(negedge clk);
            n_checks++;
            if (ack_end !== 1'b0 || depth !== 4'(m_id.size()) || active_valid !== (m_id.size() != 0)) begin
                n_fail++;
                $display("FAIL after_pop: ack=%0b depth=%0d valid=%0b want 0/%0d/%0b",
                         ack_end, depth, active_valid, m_id.size(), m_id.size() != 0);
            end
            if (m_id.size() > 0) begin
                n_checks++;
                if (active_id !== m_id[m_id.size()-1] || active_priority !== m_pri[m_pri.size()-1]) begin
                    n_fail++;
                    $display("FAIL new_top: id=%0d pri=%0d want %0d/%0d", active_id, active_priority,
                             m_id[m_id.size()-1], m_pri[m_pri.size()-1]);
                end
            end
        end else begin
            m_err = 1'b1;
            n_checks++;
            if (ack_end !== 1'b0 || depth !== 4'd0) begin
                n_fail++; $display("FAIL empty_reti: ack_end=%0b depth=%0d want 0/0", ack_end, depth);
            end
        end
        n_checks++;
        if (err_reti !== m_err) begin
            n_fail++; $display("FAIL err_reti: got %0b want %0b", err_reti, m_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw_gie = 1'b0; int_flag = 1'b0; irq_ack = 1'b0; cpu_reti = 1'b0;
        int_id = 5'd0; int_priority = 3'd0; ivt_base = 32'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b0 || ack_start !== 1'b0 || ack_end !== 1'b0 || active_valid !== 1'b0 ||
            depth !== 4'd0 || err_reti !== 1'b0 || irq_vector !== 32'd0 || ack_start_id !== 5'd0 ||
            ack_end_id !== 5'd0 || active_id !== 5'd0 || active_priority !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%0b as=%0b ae=%0b av=%0b depth=%0d err=%0b vec=%h want all 0",
                     irq_req, ack_start, ack_end, active_valid, depth, err_reti, irq_vector);
        end
        rst_n = 1'b1; sw_gie = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        do_dispatch(5'd5, 3'd1, 1'b1, 32'h0000_1000, 2);
        n_checks++;
        if (irq_vector !== 32'h0000_1014) begin
            n_fail++; $display("FAIL single_vector: got %h want 00001014", irq_vector);
        end
        do_reti();
    endtask

    task automatic test_nesting();
        do_dispatch(5'd12, 3'd3, 1'b1, 32'h2000_0000, 0);
        do_dispatch(5'd2, 3'd0, 1'b1, 32'h2000_0000, 1);
        n_checks++;
        if (depth !== 4'd2) begin n_fail++; $display("FAIL nest_depth: got %0d want 2", depth); end
        do_dispatch(5'd13, 3'd3, 1'b1, 32'h2000_0000, 0);
        do_reti();
        do_reti();
    endtask

    task automatic test_equal_prio();
        do_dispatch(5'd8, 3'd2, 1'b1, 32'hFFFF_FFF0, 0);
        do_dispatch(5'd9, 3'd2, 1'b1, 32'hFFFF_FFF0, 0);
        do_reti();
        do_dispatch(5'd9, 3'd2, 1'b1, 32'hFFFF_FFF0, 0);
        do_reti();
    endtask

    task automatic test_stack_full();
        for (int p = 3; p >= 0; p--) do_dispatch(5'(20 + p), 3'(p), 1'b1, 32'h0000_4000, 0);
        do_dispatch(5'd31, 3'd0, 1'b1, 32'h0000_4000, 0);
        n_checks++;
        if (depth !== 4'd4) begin n_fail++; $display("FAIL full_depth: got %0d want 4", depth); end
        repeat (4) do_reti();
    endtask

    task automatic test_gie_off();
        do_dispatch(5'd6, 3'd5, 1'b1, 32'h0000_0100, 0);
        do_dispatch(5'd7, 3'd1, 1'b0, 32'h0000_0100, 0);
        n_checks++;
        if (depth !== 4'd1 || active_id !== 5'd6) begin
            n_fail++; $display("FAIL gie_off_stack: depth=%0d id=%0d want 1/6", depth, active_id);
        end
        do_reti();
    endtask

    task automatic test_empty_reti();
        do_reti();
        do_reti();
        do_dispatch(5'd3, 3'd4, 1'b1, 32'h0000_0200, 0);
        do_reti();
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                do_dispatch(5'($urandom), 3'($urandom), ($urandom_range(0, 7) != 0), $urandom,
                            int'($urandom_range(0, 3)));
            end else begin
                do_reti();
            end
        end
        while (m_id.size() > 0) do_reti();
    endtask

    task automatic test_reset_in_req();
        @(negedge clk);
        int_flag = 1'b1; int_id = 5'd7; int_priority = 3'd4; sw_gie = 1'b1; ivt_base = 32'h0000_3000;
        @(negedge clk);
        n_checks++;
        if (irq_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req: got %0b want 1", irq_req); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (irq_req !== 1'b0 || ack_start !== 1'b0 || depth !== 4'd0 || err_reti !== 1'b0 ||
            irq_vector !== 32'd0 || active_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_req: req=%0b as=%0b depth=%0d err=%0b vec=%h av=%0b want 0",
                     irq_req, ack_start, depth, err_reti, irq_vector, active_valid);
        end
        int_flag = 1'b0; irq_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; irq_ack = 1'b0;
        m_id.delete(); m_pri.delete(); m_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (ack_start !== 1'b0 || irq_req !== 1'b0 || depth !== 4'd0) begin
                n_fail++; $display("FAIL post_reset_quiet: as=%0b req=%0b depth=%0d want 0/0/0",
                                   ack_start, irq_req, depth);
            end
        end
        do_dispatch(5'd4, 3'd2, 1'b1, 32'h0000_5000, 1);
        do_reti();
    endtask

    initial begin
        test_reset();
        test_single();
        test_nesting();
        test_equal_prio();
        test_stack_full();
        test_gie_off();
        test_empty_reti();
        test_random();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
